// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Op codes, FSM states and shared helpers for the alu_mc ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

  localparam int WORD_SIZE = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_MUL   = 4'd10,
    ALU_MULHU = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_REMU  = 4'd13
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_seq
// Purpose  : Iterative unsigned multiply (shift-add) / divide (restoring),
//            one iteration per cycle. Present only with ALU_MC_MULDIV_EN.
// Revision : 1.0 - initial release
// ============================================================================
`ifdef ALU_MC_MULDIV_EN
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  logic             r_busy;
  logic [SHW-1:0]   r_cnt;
  logic             r_div;
  logic             r_hi_sel;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_hi_n;
  logic [WIDTH-1:0] w_lo_n;

  // hi/lo double as product {hi,lo} for multiply and {remainder,quotient} for divide
  assign w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_sh   = {r_hi, r_lo[WIDTH-1]};
  assign w_ge   = (w_sh >= {1'b0, r_b});
  assign w_diff = w_sh[WIDTH-1:0] - r_b;

  always_comb begin
    if (r_div) begin
      w_hi_n = w_ge ? w_diff : w_sh[WIDTH-1:0];
      w_lo_n = {r_lo[WIDTH-2:0], w_ge};
    end else begin
      w_hi_n = w_sum[WIDTH:1];
      w_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};
    end
  end

  assign done = r_busy && (r_cnt == '0);
  assign res  = r_hi_sel ? w_hi_n : w_lo_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_div    <= 1'b0;
      r_hi_sel <= 1'b0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (start) begin
      r_busy   <= 1'b1;
      r_cnt    <= SHW'(WIDTH - 1);
      r_div    <= (op == ALU_DIVU) || (op == ALU_REMU);
      r_hi_sel <= (op == ALU_MULHU) || (op == ALU_REMU);
      r_b      <= b;
      r_hi     <= '0;
      r_lo     <= a;
    end else if (r_busy) begin
      r_hi <= w_hi_n;
      r_lo <= w_lo_n;
      if (r_cnt == '0) r_busy <= 1'b0;
      else             r_cnt  <= r_cnt - 1'b1;
    end
  end

endmodule
`endif
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle integer ALU with valid/ready handshake on both sides.
//            Define ALU_MC_MULDIV_EN to enable MUL/MULHU/DIVU/REMU.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = WORD_SIZE,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  alu_state_t       r_state;
  alu_state_t       w_next;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic             w_accept;
  logic             w_go_busy;
  logic             w_illegal;
  logic             w_load;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_sc_res;
  logic [WIDTH-1:0] w_res_next;
  logic             w_md_done;
  logic [WIDTH-1:0] w_md_res;

  assign w_accept = (r_state == S_IDLE) && in_valid;
  assign w_shamt  = b[SHW-1:0];

`ifdef ALU_MC_MULDIV_EN
  assign w_go_busy = is_muldiv(op);
  assign w_illegal = (op > ALU_REMU);

  alu_muldiv_seq #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_accept && w_go_busy),
    .op    (op),
    .a     (a),
    .b     (b),
    .done  (w_md_done),
    .res   (w_md_res)
  );
`else
  assign w_go_busy = 1'b0;
  assign w_illegal = is_muldiv(op) || (op > ALU_REMU);
  assign w_md_done = 1'b0;
  assign w_md_res  = '0;
`endif

  // Mul/div and illegal codes fall to the default and yield zero here
  always_comb begin
    w_sc_res = '0;
    case (op)
      ALU_ADD:  w_sc_res = a + b;
      ALU_SUB:  w_sc_res = a - b;
      ALU_AND:  w_sc_res = a & b;
      ALU_OR:   w_sc_res = a | b;
      ALU_XOR:  w_sc_res = a ^ b;
      ALU_SLL:  w_sc_res = a << w_shamt;
      ALU_SRL:  w_sc_res = a >> w_shamt;
      ALU_SRA:  w_sc_res = $unsigned($signed(a) >>> w_shamt);
      ALU_SLT:  w_sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: w_sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      default:  w_sc_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = w_go_busy ? S_BUSY : S_DONE;
      S_BUSY:  if (w_md_done) w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // zero is derived from the same next value that lands in result
  assign w_load     = (w_accept && !w_go_busy) || ((r_state == S_BUSY) && w_md_done);
  assign w_res_next = (r_state == S_BUSY) ? w_md_res : w_sc_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_load) begin
      r_result <= w_res_next;
      r_zero   <= (w_res_next == '0);
      r_err    <= (r_state == S_IDLE) && w_illegal;
    end
  end

  assign result = r_result;
  assign zero   = r_zero;
  assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_mc
// Purpose  : Self-checking bench for alu_mc (directed vectors + reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         err;

  int           n_vec = 0;
  int           n_bad = 0;
  logic         exp_on = 1'b0;
  logic [W-1:0] exp_res = '0;
  logic         exp_zero = 1'b0;
  logic         exp_err = 1'b0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on the op-code table
  function automatic logic [W-1:0] model_res(input logic [3:0] o, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [2*W-1:0] p;
    int unsigned    s;
    s = y % W;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    case (o)
      4'd0:  return x + y;
      4'd1:  return x - y;
      4'd2:  return x & y;
      4'd3:  return x | y;
      4'd4:  return x ^ y;
      4'd5:  return x << s;
      4'd6:  return x >> s;
      4'd7:  return $unsigned($signed(x) >>> s);
      4'd8:  return ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      4'd9:  return (x < y) ? W'(1) : W'(0);
`ifdef ALU_MC_MULDIV_EN
      4'd10: return p[W-1:0];
      4'd11: return p[2*W-1:W];
      4'd12: return (y == 0) ? {W{1'b1}} : x / y;
      4'd13: return (y == 0) ? x : x % y;
`endif
      default: return W'(0);
    endcase
  endfunction

  function automatic logic model_err(input logic [3:0] o);
`ifdef ALU_MC_MULDIV_EN
    return o >= 4'd14;
`else
    return o >= 4'd10;
`endif
  endfunction

  function automatic int model_lat(input logic [3:0] o);
`ifdef ALU_MC_MULDIV_EN
    if (o >= 4'd10 && o <= 4'd13) return W + 1;
`endif
    return 1;
  endfunction

  always @(negedge clk) begin
    if (rst_n && exp_on && out_valid) begin
      chk("cmp result", result, exp_res);
      chk("cmp zero", W'(zero), W'(exp_zero));
      chk("cmp err", W'(err), W'(exp_err));
    end
  end

  task automatic run(input string name, input logic [3:0] o, input logic [W-1:0] x,
                     input logic [W-1:0] y, input logic [W-1:0] lit_res,
                     input logic lit_err, input int hold);
    int k;
    @(negedge clk);
    chk({name, " in_ready idle"}, W'(in_ready), W'(1));
    exp_res  = model_res(o, x, y);
    exp_zero = (exp_res == '0);
    exp_err  = model_err(o);
    exp_on   = 1'b1;
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = 1;
    // Operands scrambled after the accept edge must not affect the result
    in_valid = 1'b0;
    op = 4'($urandom); a = $urandom; b = $urandom;
    while (!out_valid && k < W + 10) begin
      @(negedge clk);
      k++;
    end
    chk({name, " latency"}, W'(k), W'(model_lat(o)));
    chk({name, " literal result"}, result, lit_res);
    chk({name, " literal err"}, W'(err), W'(lit_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({name, " in_ready held"}, W'(in_ready), W'(0));
      chk({name, " out_valid held"}, W'(out_valid), W'(1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_on = 1'b0;
    chk({name, " out_valid drop"}, W'(out_valid), W'(0));
    chk({name, " in_ready back"}, W'(in_ready), W'(1));
  endtask

  initial begin
    int seen;
    @(negedge clk);
    chk("reset in_ready", W'(in_ready), W'(1));
    chk("reset out_valid", W'(out_valid), W'(0));
    chk("reset result", result, W'(0));
    chk("reset zero", W'(zero), W'(0));
    chk("reset err", W'(err), W'(0));
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("idle no out_valid", W'(seen), W'(0));

    run("SUB 5-5",      4'd1, 32'd5,         32'd5,         32'h0000_0000, 1'b0, 0);
    run("ADD wrap",     4'd0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 0);
    run("SRA",          4'd7, 32'h8000_0000, 32'h21,        32'hC000_0000, 1'b0, 0);
    run("SLT",          4'd8, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b0, 0);
    run("SLTU",         4'd9, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b0, 0);
    run("AND",          4'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234, 1'b0, 0);
    run("OR",           4'd3, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 0);
    run("XOR",          4'd4, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 1'b0, 0);
    run("SLL",          4'd5, 32'd1,         32'd31,        32'h8000_0000, 1'b0, 0);
    run("SRL",          4'd6, 32'h8000_0000, 32'h3F,        32'h0000_0001, 1'b0, 0);
    run("ADD backpres", 4'd0, 32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1'b0, 10);
    run("illegal 15",   4'd15, 32'd3,        32'd4,         32'h0000_0000, 1'b1, 0);
    run("illegal 14",   4'd14, 32'd9,        32'd9,         32'h0000_0000, 1'b1, 0);
`ifdef ALU_MC_MULDIV_EN
    run("MUL 7x6",      4'd10, 32'd7,        32'd6,         32'd42,        1'b0, 0);
    run("MUL lo",       4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    run("MULHU",        4'd11, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 1'b0, 0);
    run("DIVU 100/7",   4'd12, 32'd100,      32'd7,         32'd14,        1'b0, 0);
    run("REMU 100/7",   4'd13, 32'd100,      32'd7,         32'd2,         1'b0, 3);
    run("DIVU /0",      4'd12, 32'h1234,     32'd0,         32'hFFFF_FFFF, 1'b0, 0);
    run("REMU /0",      4'd13, 32'h1234,     32'd0,         32'h0000_1234, 1'b0, 0);

    // Reset in the middle of a multiply aborts it
    @(negedge clk);
    op = 4'd10; a = 32'd3; b = 32'd3; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("busy in_ready", W'(in_ready), W'(0));
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", W'(in_ready), W'(1));
    chk("abort out_valid", W'(out_valid), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < W + 5; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    chk("abort no out_valid", W'(seen), W'(0));
    run("post-abort ADD", 4'd0, 32'd2,       32'd3,         32'd5,         1'b0, 0);
`else
    run("MUL disabled", 4'd10, 32'd7,        32'd6,         32'h0000_0000, 1'b1, 0);
    run("REMU disabled", 4'd13, 32'd100,     32'd7,         32'h0000_0000, 1'b1, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parameterised integer ALU for the tinyCPU execute stage. Adds a valid/ready handshake on both sides so it can stall the pipeline. Single-cycle logic/arith/shift/compare ops complete in one cycle. Optional iterative unsigned multiply/divide takes WIDTH cycles. `result` and `zero` are registered together and always describe the same operation.

## Interface
Parameters:
- WIDTH, default `WORD_SIZE` (32): operand/result width, ≥ 8, power of two.
- SHW, default $clog2(WIDTH): shift-amount width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request present.
- in_ready  out  1  ALU can accept a request.
- op  in  4  operation code (see Operation).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/zero/err valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  operation result.
- zero  out  1  result == 0.
- err  out  1  illegal op code (or mul/div op with the feature compiled out).

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed), 9 SLTU, 10 MUL (low WIDTH bits), 11 MULHU (high WIDTH bits, unsigned), 12 DIVU, 13 REMU, 14–15 illegal.
- All arithmetic is modulo 2^WIDTH and carries are discarded. Shifts use b[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended.
- DIVU with b==0 returns all-ones. REMU with b==0 returns a. Neither case sets err.
- Illegal op: result 0, zero 1, err 1, single-cycle latency.
- FSM has three states:
  - IDLE: in_ready=1. When in_valid is high, operands and op are captured. Single-cycle ops go to DONE. Ops 10–13 go to BUSY.
  - BUSY: one iteration per cycle with a down-counter starting at WIDTH-1. Shift-add is used for multiply and restoring division for divide. When the counter reaches 0, go to DONE.
  - DONE: out_valid=1 and outputs are held stable. When out_ready is high, go to IDLE.
- in_ready is high only in IDLE. No request can be accepted in the same cycle a result is taken.
- Inputs are sampled only on the accept edge. Input changes afterwards are ignored.

## Timing
- Reset state: IDLE, in_ready=1, out_valid=0, result=0, zero=0, err=0, counter=0.
- Single-cycle op accepted at edge N: out_valid=1 from edge N+1.
- Mul/div op accepted at edge N: out_valid=1 from edge N+WIDTH+1.
- Peak throughput for single-cycle ops is one result per 2 cycles.
- out_valid, result, zero and err are all registered. zero is computed from the next-result value in the same edge, so it is never stale.
- Reset asserted mid-operation aborts it immediately. No out_valid follows.
- out_ready high while out_valid=0 has no effect.
- Back-pressure: DONE may be held indefinitely with outputs constant.

## Configuration
- `ALU_MC_MULDIV_EN` defined: ops 10–13 are implemented as above, and the BUSY state and datapath are present.
- Not defined: ops 10–13 are treated as illegal (err=1, result 0, one-cycle latency). No BUSY logic is synthesised.

## Structure
- `alu_pkg` holds:
  - the op-code enum/localparams (ALU_ADD … ALU_REMU);
  - the FSM state enum (S_IDLE, S_BUSY, S_DONE);
  - WORD_SIZE default.
- Sub-module `alu_muldiv_seq` holds the iterative multiply/divide engine. Interface: start, op, a, b, done, res. It is instantiated only under `ALU_MC_MULDIV_EN`.
- The top level holds the handshake FSM, the combinational single-cycle ops and the output registers.

## Test plan
- Reset: rst_n=0 → in_ready=1, out_valid=0, result=0, zero=0, err=0. Release, then idle for 5 cycles → no out_valid.
- ADD/SUB, WIDTH=32:
  - a=5, b=5, SUB → result 0, zero=1, out_valid 1 cycle after accept.
  - a=0xFFFF_FFFF, b=1, ADD → result 0, zero=1.
- Shift/compare:
  - SRA a=0x8000_0000, b=0x21 (amount 1) → 0xC000_0000.
  - SLT a=0xFFFF_FFFF, b=1 → 1.
  - SLTU with the same operands → 0.
- Back-pressure: hold out_ready=0 for 10 cycles → result stable, in_ready=0. Assert out_ready → in_ready=1 the next cycle.
- Mul/div (macro on):
  - MUL 7×6 → 42 at accept+33.
  - MULHU 0xFFFF_FFFF×2 → 1.
  - DIVU 100/7 → 14.
  - REMU 100/7 → 2.
  - DIVU x/0 → 0xFFFF_FFFF.
  - Assert reset during BUSY → no out_valid, and IDLE follows.
- Macro off / illegal op: op=10 or op=15 → err=1, result 0, zero=1, one-cycle latency.
